pipeline_hazard_ctrl: RTL and testbench

Hazard and stall sequencer for the 5-stage MIPS pipeline. It drives the write-enable and flush controls of the PC, the IF/ID register and the ID/EX register. It handles three cases: load-use hazards, taken-branch flushes, and structural/HI-LO hazards against a multi-cycle multiply/divide unit, which it tracks with an internal busy FSM and counter. The ID/EX register inserts a bubble by loading all-zero control fields when IDEX_Flush is high.

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS pipeline datapath
// and the stall/flush sequencer.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  Rs_ID;
  logic [4:0]  Rt_ID;
  logic        UsesRt_ID;
  logic        MulDiv_ID;
  logic        HiLoRead_ID;
  logic        MemRead_EX;
  logic [4:0]  LoadDest_EX;
  logic        BranchTaken_EX;
  logic        MulDivStart_EX;
  logic        PCWrite;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        MulDivBusy;
  logic        ProtoErr;
  logic [31:0] StallCycles;

  modport master (
    output Rs_ID, Rt_ID, UsesRt_ID,
    output MulDiv_ID, HiLoRead_ID,
    output MemRead_EX, LoadDest_EX,
    output BranchTaken_EX, MulDivStart_EX,
    input  PCWrite, IFID_Write,
    input  IFID_Flush, IDEX_Flush,
    input  MulDivBusy, ProtoErr,
    input  StallCycles
  );

  modport slave (
    input  Rs_ID, Rt_ID, UsesRt_ID,
    input  MulDiv_ID, HiLoRead_ID,
    input  MemRead_EX, LoadDest_EX,
    input  BranchTaken_EX, MulDivStart_EX,
    output PCWrite, IFID_Write,
    output IFID_Flush, IDEX_Flush,
    output MulDivBusy, ProtoErr,
    output StallCycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use, branch-flush and mult/div hazard sequencer
// for the 5-stage MIPS pipeline.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT = 32,
  parameter int CNT_W      = 6
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {
    RUN,
    MULDIV
  } state_e;

  state_e fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic perr_q, perr_d;
  logic [31:0] stall_q, stall_d;

  logic busy;
  logic loaduse;
  logic mdhaz;
  logic start_ok;
  logic start_bad;
  logic pc_w;

  always_comb begin
    busy = (fsm_q == MULDIV) | hz.MulDivStart_EX;
    loaduse = hz.MemRead_EX
            & (hz.LoadDest_EX != 5'd0)
            & ((hz.LoadDest_EX == hz.Rs_ID)
            | (hz.UsesRt_ID
            & (hz.LoadDest_EX == hz.Rt_ID)));
    mdhaz = busy & (hz.MulDiv_ID | hz.HiLoRead_ID);
    start_bad = hz.MulDivStart_EX
              & ((fsm_q == MULDIV) | hz.BranchTaken_EX);
    start_ok = hz.MulDivStart_EX & ~start_bad;
  end

  // Reset outranks branch, branch outranks any stall.
  always_comb begin
    pc_w          = 1'b1;
    hz.IFID_Write = 1'b1;
    hz.IFID_Flush = 1'b0;
    hz.IDEX_Flush = 1'b0;
    priority case (1'b1)
      rst: begin
        pc_w          = 1'b0;
        hz.IFID_Write = 1'b0;
        hz.IFID_Flush = 1'b1;
        hz.IDEX_Flush = 1'b1;
      end
      hz.BranchTaken_EX: begin
        hz.IFID_Flush = 1'b1;
        hz.IDEX_Flush = 1'b1;
      end
      (loaduse | mdhaz): begin
        pc_w          = 1'b0;
        hz.IFID_Write = 1'b0;
        hz.IDEX_Flush = 1'b1;
      end
      default: ;
    endcase
    hz.PCWrite     = pc_w;
    hz.MulDivBusy  = busy & ~rst;
    hz.ProtoErr    = perr_q;
    hz.StallCycles = stall_q;
  end

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q | start_bad;
    stall_d = pc_w ? stall_q : stall_q + 32'd1;
    unique case (fsm_q)
      RUN: begin
        if (start_ok) begin
          fsm_d = MULDIV;
          cnt_d = CNT_W'(MULDIV_LAT - 1);
        end
      end
      MULDIV: begin
        if (cnt_q == CNT_W'(1)) begin
          fsm_d = RUN;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        fsm_d = RUN;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= RUN;
      cnt_q   <= '0;
      perr_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for the hazard sequencer,
// built with a 4-cycle mult/div latency.
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] NORM = 4'b1100;
  localparam logic [3:0] STL  = 4'b0001;
  localparam logic [3:0] BRF  = 4'b1111;
  localparam logic [3:0] RSTC = 4'b0011;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic        busy;
    logic        perr;
    logic [31:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MULDIV_LAT(4),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  always #5 clk = ~clk;

  task automatic vec(
    input string n, input logic r,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic urt, input logic md, input logic hl,
    input logic mr, input logic [4:0] ld,
    input logic br, input logic ms,
    input logic [3:0] ctl, input logic bz,
    input logic pe, input logic [31:0] st);
    exp_t e;
    @(negedge clk);
    rst               = r;
    hz.Rs_ID          = rs;
    hz.Rt_ID          = rt;
    hz.UsesRt_ID      = urt;
    hz.MulDiv_ID      = md;
    hz.HiLoRead_ID    = hl;
    hz.MemRead_EX     = mr;
    hz.LoadDest_EX    = ld;
    hz.BranchTaken_EX = br;
    hz.MulDivStart_EX = ms;
    e.name = n;
    e.ctl  = ctl;
    e.busy = bz;
    e.perr = pe;
    e.st   = st;
    sb.push_back(e);
  endtask

  // Monitor: one expected response per cycle, sampled
  // mid-phase after the driver has settled the inputs.
  initial begin
    exp_t e;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {hz.PCWrite, hz.IFID_Write,
               hz.IFID_Flush, hz.IDEX_Flush};
        n_vec++;
        if (act !== e.ctl || hz.MulDivBusy !== e.busy
            || hz.ProtoErr !== e.perr
            || hz.StallCycles !== e.st) begin
          n_bad++;
          $display("FAIL %s: got ctl=%b busy=%b perr=%b st=%0d, want ctl=%b busy=%b perr=%b st=%0d",
            e.name, act, hz.MulDivBusy, hz.ProtoErr,
            hz.StallCycles, e.ctl, e.busy, e.perr, e.st);
        end
      end
    end
  end

  initial begin
    rst               = 1'b1;
    hz.Rs_ID          = '0;
    hz.Rt_ID          = '0;
    hz.UsesRt_ID      = 1'b0;
    hz.MulDiv_ID      = 1'b0;
    hz.HiLoRead_ID    = 1'b0;
    hz.MemRead_EX     = 1'b0;
    hz.LoadDest_EX    = '0;
    hz.BranchTaken_EX = 1'b0;
    hz.MulDivStart_EX = 1'b0;
    @(posedge clk);
    //    name      r rs rt u md hl mr ld br ms ctl bz pe st
    vec("reset",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RSTC, 0, 0, 0);
    vec("idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
    vec("lu_rs",    0, 5, 0, 0, 0, 0, 1, 5, 0, 0, STL,  0, 0, 0);
    vec("lu_after", 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 1);
    vec("lu_rt",    0, 3, 9, 1, 0, 0, 1, 9, 0, 0, STL,  0, 0, 1);
    vec("ld_zero",  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, NORM, 0, 0, 2);
    vec("rt_unused",0, 1, 7, 0, 0, 0, 1, 7, 0, 0, NORM, 0, 0, 2);
    vec("md_T0",    0, 0, 0, 0, 0, 1, 0, 0, 0, 1, STL,  1, 0, 2);
    vec("md_T1",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STL,  1, 0, 3);
    vec("md_T2",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STL,  1, 0, 4);
    vec("md_T3",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STL,  1, 0, 5);
    vec("md_T4",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0, 6);
    vec("br_T0",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 1, 0, 6);
    vec("br_T1",    0, 0, 0, 0, 0, 1, 0, 0, 1, 0, BRF,  1, 0, 6);
    vec("br_T2",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STL,  1, 0, 6);
    vec("br_T3",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STL,  1, 0, 7);
    vec("br_T4",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0, 8);
    vec("pe_T0",    0, 0, 0, 0, 1, 0, 0, 0, 0, 1, STL,  1, 0, 8);
    vec("pe_T1",    0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 1, 0, 9);
    vec("pe_T2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 1, 9);
    vec("pe_T3",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 1, 1, 9);
    vec("pe_T4",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 1, 9);
    vec("sb_both",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, BRF,  1, 1, 9);
    vec("sb_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 1, 9);
    vec("rst_clr",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTC, 0, 1, 9);
    vec("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
    vec("sb2",      0, 0, 0, 0, 0, 0, 0, 0, 1, 1, BRF,  1, 0, 0);
    vec("sb2_after",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 1, 0);
    vec("rm_T0",    0, 0, 0, 0, 0, 1, 0, 0, 0, 1, STL,  1, 1, 0);
    vec("rm_T1",    0, 0, 0, 0, 0, 1, 0, 0, 0, 0, STL,  1, 1, 1);
    vec("rm_rst",   1, 0, 0, 0, 0, 1, 0, 0, 0, 0, RSTC, 0, 1, 2);
    vec("rm_after", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0, 0);
    repeat (3) @(negedge clk);
    #4;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
